// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// ahb3lite_interconnect_slave_arbiter: highest-priority / round-robin owner selection for one slave port.
// Optional starvation guard: define AHB3LITE_ARB_AGING_EN to add per-master age counters.
module ahb3lite_interconnect_slave_arbiter #(
    parameter int  MASTERS   = 3,
    parameter int  AGE_LIMIT = 15,
    localparam int IW        = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic                    HRESETn,
    input  logic                    HCLK,
    input  logic [MASTERS-1:0]      mst_req,
    input  logic [MASTERS-1:0][2:0] mst_priority,
    input  logic [MASTERS-1:0]      mst_can_switch,
    input  logic                    slv_HREADY,
    output logic [MASTERS-1:0]      master_granted,
    output logic [IW-1:0]           grant_idx,
    output logic                    grant_switch
);
    logic [MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]      idx_q, idx_d, rr_q, rr_d, win;
    logic               switch_q, switch_d, switch_ok, legal, decide, found;
    logic [3:0]         best;
    logic [3:0]         eff [MASTERS];

    function automatic logic [IW-1:0] scan(input logic [IW-1:0] p, input int k);
        return IW'((int'(p) + k) % MASTERS);
    endfunction

    assign legal     = (grant_q != '0) && ((grant_q & (grant_q - MASTERS'(1))) == '0);
    assign switch_ok = slv_HREADY & (mst_can_switch[idx_q] | ~mst_req[idx_q]);
    assign decide    = legal & switch_ok & (|mst_req);

`ifdef AHB3LITE_ARB_AGING_EN
    localparam int AW = $clog2(AGE_LIMIT + 1);
    logic [AW-1:0] age_q [MASTERS];
    logic [AW-1:0] age_d [MASTERS];

    // An aged master sits above every plain priority-7 requester.
    for (genvar g = 0; g < MASTERS; g++) begin : g_eff
        assign eff[g] = (age_q[g] == AW'(AGE_LIMIT)) ? 4'hf : {1'b0, mst_priority[g]};
    end

    always_comb begin
        for (int i = 0; i < MASTERS; i++)
            age_d[i] = !mst_req[i] ? '0 :
                       !decide ? age_q[i] :
                       (win == IW'(i)) ? '0 :
                       (age_q[i] == AW'(AGE_LIMIT)) ? age_q[i] : age_q[i] + AW'(1);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) age_q <= '{default: '0};
        else          age_q <= age_d;
    end
`else
    logic unused_age;
    assign unused_age = |AGE_LIMIT;
    for (genvar g = 0; g < MASTERS; g++) begin : g_eff
        assign eff[g] = {1'b0, mst_priority[g]};
    end
`endif

    // Scan starts just after the last owner, so strict '>' keeps the earliest tied requester.
    always_comb begin
        win   = rr_q;
        best  = '0;
        found = 1'b0;
        for (int k = 1; k <= MASTERS; k++) begin
            if (mst_req[scan(rr_q, k)] && (!found || eff[scan(rr_q, k)] > best)) begin
                found = 1'b1;
                best  = eff[scan(rr_q, k)];
                win   = scan(rr_q, k);
            end
        end
    end

    always_comb begin
        grant_d  = grant_q;
        idx_d    = idx_q;
        rr_d     = rr_q;
        switch_d = 1'b0;
        if (!legal) begin
            grant_d  = MASTERS'(1);
            idx_d    = '0;
            switch_d = 1'b1;
        end else if (decide) begin
            grant_d  = MASTERS'(1) << win;
            idx_d    = win;
            rr_d     = win;
            switch_d = win != idx_q;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q  <= MASTERS'(1);
            idx_q    <= '0;
            rr_q     <= '0;
            switch_q <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            rr_q     <= rr_d;
            switch_q <= switch_d;
        end
    end

    assign master_granted = grant_q;
    assign grant_idx      = idx_q;
    assign grant_switch   = switch_q;
endmodule
